dac_sample_feeder: RTL and testbench

DAC_SAMPLE_FEEDER -- requirements
Module: dac_sample_feeder

---
 rtl/dac_sample_feeder.sv | 95 +++++++++
 tb/tb_dac_sample_feeder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_feeder.sv
// rtl/dac_sample_feeder.sv - stereo sample FIFO feeding a serial DAC stage on dac_lr frame edges
// Optional build macro: FEEDER_UNDERRUN_HOLD_EN (repeat last sample on underrun instead of muting).
module dac_sample_feeder (
    input  logic        clk,
    input  logic        enable,
    input  logic        dac_lr,
    input  logic [23:0] in_left,
    input  logic [23:0] in_right,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [32:0] SDACL,
    output logic [32:0] SDACR,
    output logic [2:0]  fifo_level,
    output logic        underrun,
    output logic [7:0]  underrun_count
);

    logic [47:0] r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_level;
    logic        r_dac_lr_q;
    logic [32:0] r_sdacl;
    logic [32:0] r_sdacr;
    logic        r_underrun;
    logic [7:0]  r_underrun_count;

    logic        w_boundary;
    logic        w_push;
    logic        w_pop;
    logic        w_underrun;
    logic [47:0] w_head;

    // Ready depends only on stored occupancy, never on this cycle's pop.
    assign in_ready   = enable && (r_level < 3'd4);
    assign w_boundary = enable && dac_lr && !r_dac_lr_q;
    assign w_push     = in_valid && in_ready;
    assign w_pop      = w_boundary && (r_level != 3'd0);
    assign w_underrun = w_boundary && (r_level == 3'd0);
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_left, in_right};
        end
    end

    always_ff @(posedge clk) begin
        if (!enable) begin
            r_wr_ptr         <= 2'd0;
            r_rd_ptr         <= 2'd0;
            r_level          <= 3'd0;
            r_dac_lr_q       <= 1'b1;
            r_sdacl          <= 33'd0;
            r_sdacr          <= 33'd0;
            r_underrun       <= 1'b0;
            r_underrun_count <= 8'd0;
        end else begin
            r_dac_lr_q <= dac_lr;
            r_underrun <= w_underrun;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
                r_sdacl  <= {w_head[47:24], 9'd0};
                r_sdacr  <= {w_head[23:0], 9'd0};
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 3'd1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 3'd1;
            end
            if (w_underrun) begin
`ifdef FEEDER_UNDERRUN_HOLD_EN
                r_sdacl <= r_sdacl;
                r_sdacr <= r_sdacr;
`else
                r_sdacl <= 33'd0;
                r_sdacr <= 33'd0;
`endif
                if (r_underrun_count != 8'hFF) begin
                    r_underrun_count <= r_underrun_count + 8'd1;
                end
            end
        end
    end

    assign SDACL          = r_sdacl;
    assign SDACR          = r_sdacr;
    assign fifo_level     = r_level;
    assign underrun       = r_underrun;
    assign underrun_count = r_underrun_count;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb/tb_dac_sample_feeder.sv - directed vector bench for dac_sample_feeder
module tb_dac_sample_feeder;

`ifdef FEEDER_UNDERRUN_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        enable = 1'b0;
    logic        dac_lr = 1'b0;
    logic [23:0] in_left = '0;
    logic [23:0] in_right = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [32:0] SDACL;
    logic [32:0] SDACR;
    logic [2:0]  fifo_level;
    logic        underrun;
    logic [7:0]  underrun_count;

    int total = 0;
    int bad = 0;

    dac_sample_feeder dut (
        .clk            (clk),
        .enable         (enable),
        .dac_lr         (dac_lr),
        .in_left        (in_left),
        .in_right       (in_right),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .SDACL          (SDACL),
        .SDACR          (SDACR),
        .fifo_level     (fifo_level),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        lr;
        logic        vld;
        logic [23:0] l;
        logic [23:0] r;
        logic        ready;
        logic [2:0]  level;
        logic [32:0] sl;
        logic [32:0] sr;
        logic        ur;
        logic [7:0]  ucnt;
    } vec_t;

    vec_t vecs [36];

    function automatic vec_t mk(input logic en, input logic lr, input logic vld,
                                input logic [23:0] l, input logic [23:0] r,
                                input logic ready, input logic [2:0] level,
                                input logic [32:0] sl, input logic [32:0] sr,
                                input logic ur, input logic [7:0] ucnt);
        vec_t v;
        v.en = en; v.lr = lr; v.vld = vld; v.l = l; v.r = r;
        v.ready = ready; v.level = level; v.sl = sl; v.sr = sr; v.ur = ur; v.ucnt = ucnt;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        enable   = v.en;
        dac_lr   = v.lr;
        in_valid = v.vld;
        in_left  = v.l;
        in_right = v.r;
        @(posedge clk);
        #1;
        check("in_ready", idx, {32'd0, in_ready}, {32'd0, v.ready});
        check("fifo_level", idx, {30'd0, fifo_level}, {30'd0, v.level});
        check("SDACL", idx, SDACL, v.sl);
        check("SDACR", idx, SDACR, v.sr);
        check("underrun", idx, {32'd0, underrun}, {32'd0, v.ur});
        check("underrun_count", idx, {25'd0, underrun_count}, {25'd0, v.ucnt});
    endtask

    initial begin
        logic [32:0] hl;
        logic [32:0] hr;
        logic [32:0] kl;
        logic [32:0] kr;
        int          exp_cnt;

        // Reset, then scenario 1.
        vecs[0]  = mk(0, 0, 0, 24'h0,      24'h0,      0, 0, 33'h0,         33'h0,         0, 0);
        vecs[1]  = mk(0, 0, 1, 24'h999999, 24'h999999, 0, 0, 33'h0,         33'h0,         0, 0);
        vecs[2]  = mk(1, 0, 1, 24'h123456, 24'hABCDEF, 1, 1, 33'h0,         33'h0,         0, 0);
        vecs[3]  = mk(1, 1, 0, 24'h0,      24'h0,      1, 0, 33'h02468AC00, 33'h1579BDE00, 0, 0);
        vecs[4]  = mk(1, 1, 0, 24'h0,      24'h0,      1, 0, 33'h02468AC00, 33'h1579BDE00, 0, 0);
        // Scenario 2: fill to 4, fifth offer held off.
        vecs[5]  = mk(1, 0, 1, 24'h000001, 24'hFFFFFF, 1, 1, 33'h02468AC00, 33'h1579BDE00, 0, 0);
        vecs[6]  = mk(1, 0, 1, 24'h800000, 24'h7FFFFF, 1, 2, 33'h02468AC00, 33'h1579BDE00, 0, 0);
        vecs[7]  = mk(1, 0, 1, 24'h111111, 24'h222222, 1, 3, 33'h02468AC00, 33'h1579BDE00, 0, 0);
        vecs[8]  = mk(1, 0, 1, 24'h333333, 24'h444444, 0, 4, 33'h02468AC00, 33'h1579BDE00, 0, 0);
        vecs[9]  = mk(1, 0, 1, 24'h555555, 24'h666666, 0, 4, 33'h02468AC00, 33'h1579BDE00, 0, 0);
        // Scenario 3: push + edge while full pops only.
        vecs[10] = mk(1, 1, 1, 24'h555555, 24'h666666, 1, 3, 33'h000000200, 33'h1FFFFFE00, 0, 0);
        vecs[11] = mk(1, 0, 1, 24'h555555, 24'h666666, 0, 4, 33'h000000200, 33'h1FFFFFE00, 0, 0);
        vecs[12] = mk(1, 1, 1, 24'h777777, 24'h888888, 1, 3, 33'h100000000, 33'h0FFFFFE00, 0, 0);
        vecs[13] = mk(1, 0, 0, 24'h0,      24'h0,      1, 3, 33'h100000000, 33'h0FFFFFE00, 0, 0);
        // Simultaneous push and pop below full keeps the level.
        vecs[14] = mk(1, 1, 1, 24'h777777, 24'h888888, 1, 3, 33'h022222200, 33'h044444400, 0, 0);
        vecs[15] = mk(1, 0, 0, 24'h0,      24'h0,      1, 3, 33'h022222200, 33'h044444400, 0, 0);
        vecs[16] = mk(1, 1, 0, 24'h0,      24'h0,      1, 2, 33'h066666600, 33'h088888800, 0, 0);
        vecs[17] = mk(1, 0, 0, 24'h0,      24'h0,      1, 2, 33'h066666600, 33'h088888800, 0, 0);
        vecs[18] = mk(1, 1, 0, 24'h0,      24'h0,      1, 1, 33'h0AAAAAA00, 33'h0CCCCCC00, 0, 0);
        vecs[19] = mk(1, 0, 0, 24'h0,      24'h0,      1, 1, 33'h0AAAAAA00, 33'h0CCCCCC00, 0, 0);
        vecs[20] = mk(1, 1, 0, 24'h0,      24'h0,      1, 0, 33'h0EEEEEE00, 33'h111111000, 0, 0);
        // Scenario 4: three underruns on an empty FIFO, the last with a same-cycle push.
        hl = HOLD ? 33'h0EEEEEE00 : 33'h0;
        hr = HOLD ? 33'h111111000 : 33'h0;
        vecs[21] = mk(1, 0, 0, 24'h0,      24'h0,      1, 0, 33'h0EEEEEE00, 33'h111111000, 0, 0);
        vecs[22] = mk(1, 1, 0, 24'h0,      24'h0,      1, 0, hl, hr, 1, 1);
        vecs[23] = mk(1, 0, 0, 24'h0,      24'h0,      1, 0, hl, hr, 0, 1);
        vecs[24] = mk(1, 1, 0, 24'h0,      24'h0,      1, 0, hl, hr, 1, 2);
        vecs[25] = mk(1, 0, 0, 24'h0,      24'h0,      1, 0, hl, hr, 0, 2);
        vecs[26] = mk(1, 1, 1, 24'h0A0A0A, 24'h050505, 1, 1, hl, hr, 1, 3);
        vecs[27] = mk(1, 0, 0, 24'h0,      24'h0,      1, 1, hl, hr, 0, 3);
        vecs[28] = mk(1, 1, 0, 24'h0,      24'h0,      1, 0, 33'h014141400, 33'h00A0A0A00, 0, 3);
        // Scenario 6: two pairs queued, reset with dac_lr held high through release.
        kl = HOLD ? 33'h014141400 : 33'h0;
        kr = HOLD ? 33'h00A0A0A00 : 33'h0;
        vecs[29] = mk(1, 0, 1, 24'h010203, 24'h040506, 1, 1, kl, kr, 0, 8'hFF);
        vecs[30] = mk(1, 0, 1, 24'h070809, 24'h0A0B0C, 1, 2, kl, kr, 0, 8'hFF);
        vecs[31] = mk(0, 1, 1, 24'h0D0E0F, 24'h101112, 0, 0, 33'h0, 33'h0, 0, 0);
        vecs[32] = mk(1, 1, 0, 24'h0,      24'h0,      1, 0, 33'h0, 33'h0, 0, 0);
        vecs[33] = mk(1, 0, 0, 24'h0,      24'h0,      1, 0, 33'h0, 33'h0, 0, 0);
        vecs[34] = mk(1, 1, 0, 24'h0,      24'h0,      1, 0, 33'h0, 33'h0, 1, 1);
        vecs[35] = mk(1, 1, 0, 24'h0,      24'h0,      1, 0, 33'h0, 33'h0, 0, 1);

        for (int i = 0; i < 29; i++) begin
            run_vec(i);
        end

        // Scenario 5: 300 more underruns, count saturates at 255.
        exp_cnt = 3;
        in_valid = 1'b0;
        for (int k = 0; k < 300; k++) begin
            dac_lr = 1'b0;
            @(posedge clk);
            #1;
            dac_lr = 1'b1;
            @(posedge clk);
            #1;
            if (exp_cnt < 255) exp_cnt++;
            check("sat_underrun", 100 + k, {32'd0, underrun}, 33'd1);
            check("sat_count", 100 + k, {25'd0, underrun_count}, exp_cnt[32:0]);
        end
        dac_lr = 1'b0;
        @(posedge clk);
        #1;
        check("sat_pulse_end", 400, {32'd0, underrun}, 33'd0);

        for (int i = 29; i < 36; i++) begin
            run_vec(i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
